wb_csr_bridge: RTL and testbench
================================

// Module: wb_csr_bridge
// PURPOSE
//  Initiator end of the CSR bus: turns single Wishbone slave cycles from the CPU/interconnect
//  into CSR-bus reads and writes. It drives address, write strobe and write data to all CSR
//  peripherals and collects their OR-combined read data. Sits between the Wishbone fabric
//  and every CSR-mapped core (sysctl, uart, ...).
// PARAMETERS
//  READ_WAIT   1    cycles between presenting csr_a and csr_di being valid (>=1; slaves register csr_do)
//  ADDR_LSB    2    Wishbone address bit mapped to csr_a[0] (word addressing)
// PORTS
//  sys_clk     in   1    system clock; the only clock
//  sys_rst     in   1    reset, asynchronous, active-high
//  wb_adr_i    in   32   Wishbone byte address; only bits [ADDR_LSB+13:ADDR_LSB] are used
//  wb_dat_i    in   32   Wishbone write data
//  wb_dat_o    out  32   Wishbone read data, valid while wb_ack_o=1
//  wb_cyc_i    in   1    Wishbone cycle
//  wb_stb_i    in   1    Wishbone strobe
//  wb_we_i     in   1    Wishbone write enable
//  wb_ack_o    out  1    Wishbone acknowledge, one-cycle pulse
//  csr_a       out  14   CSR address: [13:10] selects the core, [9:0] the register
//  csr_we      out  1    CSR write strobe, high for exactly one cycle per write
//  csr_do      out  32   CSR write data to the slaves
//  csr_di      in   32   OR of all slave csr_do (unselected slaves drive 0)
// BEHAVIOUR
//  - Reset (async): wb_ack_o=0, wb_dat_o=0, csr_a=0, csr_we=0, csr_do=0, wait counter=0, state IDLE.
//    Asserting sys_rst mid-transaction aborts it at once; no ack is issued.
//  - All outputs are registered. wb_sel_i does not exist; every write is a full 32-bit word.
//  - FSM states: IDLE, WRITE, READ_WAIT, READ_CAP, ACK.
//    IDLE: on cyc&stb at edge T0, latch csr_a<=wb_adr_i[ADDR_LSB+13:ADDR_LSB], csr_do<=wb_dat_i,
//          csr_we<=wb_we_i. Go to WRITE if we=1, else go to READ_WAIT with counter=READ_WAIT-1.
//    WRITE: (edge T1) csr_we<=0, wb_ack_o<=1, go to ACK. Slaves sample the write at T1.
//    READ_WAIT: decrement counter each cycle; at 0 go to READ_CAP.
//    READ_CAP: wb_dat_o<=csr_di, wb_ack_o<=1, go to ACK.
//    ACK: wb_ack_o<=0, go to IDLE. A new request is not accepted in ACK, so strobes held
//         across back-to-back cycles are never double-acked.
//  - Latency with READ_WAIT=1: write ack is high on the cycle after T1 (2 edges after the
//    request is sampled). Read ack is high on the cycle after T2 (3 edges).
//  - csr_a holds its value after a transaction until the next request. csr_we is 0 in every state
//    except the single cycle after the IDLE latch for a write.
//  - wb_cyc_i dropped in WRITE/READ_WAIT/READ_CAP (master abort): the CSR-side access that has
//    already been issued completes, but wb_ack_o stays 0 and the FSM returns to IDLE.
//  - wb_dat_o keeps its last captured value outside of reads. Upper Wishbone address bits are
//    ignored (the address space wraps every 64 KiB).
// STRUCTURE
//  - Shared include csr_defs.vh: CSR_AW=14, CSR_DW=32, CSR_SEL_MSB/LSB=13/10, FSM state encodings.
//  - Single flat module. There is no natural sub-module: the wait counter is a few lines
//    inside the FSM.
// TESTING
//  1. Write adr=0x0000_0004, dat=0xDEADBEEF -> csr_a=0x001, csr_do=0xDEADBEEF, csr_we high exactly 1 cycle, one ack.
//  2. Read adr=0x0000_0014, stub slave (1-cycle registered) returns 0x12345678 -> wb_dat_o=0x12345678 with ack, csr_we=0 throughout.
//  3. READ_WAIT=3, stub slave with 3-cycle latency returns 0xCAFEF00D -> correct data, ack 5 edges after the request.
//  4. Back-to-back write then read with stb held high -> exactly one ack per transaction, second csr_a latched only after ACK state.
//  5. wb_cyc_i dropped in READ_WAIT -> no ack, FSM returns to IDLE, the next write completes normally.
//  6. sys_rst pulsed in WRITE state -> csr_we and wb_ack_o go to 0 asynchronously; adr=0x8001_0010 afterwards -> csr_a=0x004.

Source files
------------

// File: rtl/wb_csr_bridge_pkg.sv
// rtl/wb_csr_bridge_pkg.sv - CSR bus widths and bridge FSM state encodings
`timescale 1ns/1ps
package wb_csr_bridge_pkg;

    localparam int CSR_AW = 14;
    localparam int CSR_DW = 32;

    localparam logic [2:0] ST_IDLE      = 3'd0;
    localparam logic [2:0] ST_WRITE     = 3'd1;
    localparam logic [2:0] ST_READ_WAIT = 3'd2;
    localparam logic [2:0] ST_READ_CAP  = 3'd3;
    localparam logic [2:0] ST_ACK       = 3'd4;

endpackage

// File: rtl/wb_csr_bridge.sv
// rtl/wb_csr_bridge.sv - Wishbone slave to CSR bus initiator bridge
`timescale 1ns/1ps
module wb_csr_bridge
    import wb_csr_bridge_pkg::*;
#(
    parameter int READ_WAIT = 1,
    parameter int ADDR_LSB  = 2
) (
    input  logic              sys_clk,
    input  logic              sys_rst,
    input  logic [31:0]       wb_adr_i,
    input  logic [31:0]       wb_dat_i,
    output logic [31:0]       wb_dat_o,
    input  logic              wb_cyc_i,
    input  logic              wb_stb_i,
    input  logic              wb_we_i,
    output logic              wb_ack_o,
    output logic [CSR_AW-1:0] csr_a,
    output logic              csr_we,
    output logic [CSR_DW-1:0] csr_do,
    input  logic [CSR_DW-1:0] csr_di
);

    localparam int CNT_W = (READ_WAIT > 1) ? $clog2(READ_WAIT) : 1;

    logic [2:0]       r_state;
    logic [CNT_W-1:0] r_cnt;
    logic             w_req;
    logic             w_unused_adr;

    assign w_req        = wb_cyc_i & wb_stb_i;
    assign w_unused_adr = ^wb_adr_i;

    always_ff @(posedge sys_clk or posedge sys_rst) begin
        if (sys_rst) begin
            r_state  <= ST_IDLE;
            r_cnt    <= '0;
            wb_ack_o <= 1'b0;
            wb_dat_o <= '0;
            csr_a    <= '0;
            csr_we   <= 1'b0;
            csr_do   <= '0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_req) begin
                        csr_a  <= wb_adr_i[ADDR_LSB +: CSR_AW];
                        csr_do <= wb_dat_i;
                        csr_we <= wb_we_i;
                        r_cnt  <= CNT_W'(READ_WAIT - 1);
                        r_state <= wb_we_i ? ST_WRITE : ST_READ_WAIT;
                    end
                end
                // The write strobe is already on the bus; a master abort only suppresses the ack.
                ST_WRITE: begin
                    csr_we <= 1'b0;
                    if (wb_cyc_i) begin
                        wb_ack_o <= 1'b1;
                        r_state  <= ST_ACK;
                    end else begin
                        r_state <= ST_IDLE;
                    end
                end
                ST_READ_WAIT: begin
                    if (!wb_cyc_i) begin
                        r_state <= ST_IDLE;
                    end else if (r_cnt == '0) begin
                        r_state <= ST_READ_CAP;
                    end else begin
                        r_cnt <= r_cnt - 1'b1;
                    end
                end
                ST_READ_CAP: begin
                    if (wb_cyc_i) begin
                        wb_dat_o <= csr_di;
                        wb_ack_o <= 1'b1;
                        r_state  <= ST_ACK;
                    end else begin
                        r_state <= ST_IDLE;
                    end
                end
                // Requests are ignored here so a held strobe is not acked twice.
                ST_ACK: begin
                    wb_ack_o <= 1'b0;
                    r_state  <= ST_IDLE;
                end
                default: begin
                    wb_ack_o <= 1'b0;
                    csr_we   <= 1'b0;
                    r_state  <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_wb_csr_bridge.sv
// tb/tb_wb_csr_bridge.sv - scoreboard bench for wb_csr_bridge at READ_WAIT=1 and READ_WAIT=3
`timescale 1ns/1ps
module tb_wb_csr_bridge;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst, we, sl_clr;
    logic [31:0] adr, wdat;
    logic        cyc1, stb1, cyc3, stb3;
    logic [31:0] dat_o1, dat_o3, csr_do1, csr_do3, csr_di1, csr_di3;
    logic        ack1, ack3, csr_we1, csr_we3;
    logic [13:0] csr_a1, csr_a3;

    wb_csr_bridge #(.READ_WAIT(1), .ADDR_LSB(2)) dut1 (
        .sys_clk(clk), .sys_rst(rst), .wb_adr_i(adr), .wb_dat_i(wdat), .wb_dat_o(dat_o1),
        .wb_cyc_i(cyc1), .wb_stb_i(stb1), .wb_we_i(we), .wb_ack_o(ack1),
        .csr_a(csr_a1), .csr_we(csr_we1), .csr_do(csr_do1), .csr_di(csr_di1)
    );

    wb_csr_bridge #(.READ_WAIT(3), .ADDR_LSB(2)) dut3 (
        .sys_clk(clk), .sys_rst(rst), .wb_adr_i(adr), .wb_dat_i(wdat), .wb_dat_o(dat_o3),
        .wb_cyc_i(cyc3), .wb_stb_i(stb3), .wb_we_i(we), .wb_ack_o(ack3),
        .csr_a(csr_a3), .csr_we(csr_we3), .csr_do(csr_do3), .csr_di(csr_di3)
    );

    function automatic logic [31:0] init_val(input logic [13:0] a);
        return 32'h5A5A_0000 ^ {a, 4'h9, a};
    endfunction

    // Stub slaves: dut1 sees a 1-cycle registered slave, dut3 a 3-cycle one.
    logic [31:0] smem1 [0:16383];
    logic [31:0] smem3 [0:16383];
    logic        vld1  [0:16383];
    logic        vld3  [0:16383];
    logic [31:0] p0_3, p1_3;

    always @(posedge clk) begin
        if (sl_clr) begin
            for (int i = 0; i < 16384; i++) begin
                vld1[i] <= 1'b0;
                vld3[i] <= 1'b0;
            end
        end else begin
            if (csr_we1) begin
                smem1[csr_a1] <= csr_do1;
                vld1[csr_a1]  <= 1'b1;
            end
            if (csr_we3) begin
                smem3[csr_a3] <= csr_do3;
                vld3[csr_a3]  <= 1'b1;
            end
        end
        csr_di1 <= vld1[csr_a1] ? smem1[csr_a1] : init_val(csr_a1);
        p0_3    <= vld3[csr_a3] ? smem3[csr_a3] : init_val(csr_a3);
        p1_3    <= p0_3;
        csr_di3 <= p1_3;
    end

    typedef struct {
        logic        rd;
        logic [13:0] a;
        logic [31:0] d;
    } exp_t;

    exp_t        q1[$];
    exp_t        q3[$];
    logic [31:0] ref1 [int];
    logic [31:0] ref3 [int];
    int          n_checks = 0;
    int          n_err    = 0;
    logic        pa1 = 1'b0;
    logic        pa3 = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
        n_checks++;
        if (act !== expv) begin
            n_err++;
            $display("FAIL %s: got %h want %h", name, act, expv);
        end
    endtask

    function automatic logic [31:0] ref_get(input int which, input logic [13:0] a);
        if (which == 1) return ref1.exists(int'(a)) ? ref1[int'(a)] : init_val(a);
        return ref3.exists(int'(a)) ? ref3[int'(a)] : init_val(a);
    endfunction

    always @(negedge clk) begin
        if (ack1) begin
            exp_t e;
            chk("ack1_single_cycle", {31'd0, pa1}, 32'd0);
            if (q1.size() == 0) begin
                chk("ack1_unexpected", 32'd0, 32'd1);
            end else begin
                e = q1.pop_front();
                chk("csr_a1", {18'd0, csr_a1}, {18'd0, e.a});
                if (e.rd) chk("rdata1", dat_o1, e.d);
            end
        end
        pa1 <= ack1;
    end

    always @(negedge clk) begin
        if (ack3) begin
            exp_t e;
            chk("ack3_single_cycle", {31'd0, pa3}, 32'd0);
            if (q3.size() == 0) begin
                chk("ack3_unexpected", 32'd0, 32'd1);
            end else begin
                e = q3.pop_front();
                chk("csr_a3", {18'd0, csr_a3}, {18'd0, e.a});
                if (e.rd) chk("rdata3", dat_o3, e.d);
            end
        end
        pa3 <= ack3;
    end

    // One Wishbone transfer; after_hold means the strobe stayed high from the previous ack.
    task automatic xfer(input int which, input logic w, input logic [31:0] a,
                        input logic [31:0] d, input bit hold, input bit after_hold);
        exp_t        e;
        int          lat, n, wec;
        bit          got;
        logic [13:0] ca;
        ca   = a[15:2];
        e.rd = !w;
        e.a  = ca;
        e.d  = w ? d : ref_get(which, ca);
        lat  = w ? 2 : ((which == 1) ? 3 : 5);
        if (after_hold) lat++;
        if (which == 1) begin
            if (w) ref1[int'(ca)] = d;
            q1.push_back(e);
        end else begin
            if (w) ref3[int'(ca)] = d;
            q3.push_back(e);
        end
        adr = a; wdat = d; we = w;
        if (which == 1) begin cyc1 = 1'b1; stb1 = 1'b1; end
        else begin cyc3 = 1'b1; stb3 = 1'b1; end
        n = 0; wec = 0; got = 1'b0;
        while (!got && n < 40) begin
            @(posedge clk);
            n++;
            @(negedge clk);
            if ((which == 1) ? csr_we1 : csr_we3) wec++;
            if ((which == 1) ? ack1 : ack3) got = 1'b1;
        end
        chk("ack_latency", n, lat);
        chk("csr_we_cycles", wec, {31'd0, w});
        if (w) chk("csr_do", (which == 1) ? csr_do1 : csr_do3, d);
        if (!hold) begin
            cyc1 = 1'b0; stb1 = 1'b0; cyc3 = 1'b0; stb3 = 1'b0;
            @(negedge clk);
        end
    endtask

    initial begin
        bit seen;
        rst = 1'b1; sl_clr = 1'b1; we = 1'b0; adr = '0; wdat = '0;
        cyc1 = 1'b0; stb1 = 1'b0; cyc3 = 1'b0; stb3 = 1'b0;
        repeat (2) @(negedge clk);
        sl_clr = 1'b0;
        chk("rst_ack1", {31'd0, ack1}, 32'd0);
        chk("rst_dat_o1", dat_o1, 32'd0);
        chk("rst_csr_a1", {18'd0, csr_a1}, 32'd0);
        chk("rst_csr_we1", {31'd0, csr_we1}, 32'd0);
        chk("rst_csr_do1", csr_do1, 32'd0);
        chk("rst_ack3", {31'd0, ack3}, 32'd0);
        chk("rst_dat_o3", dat_o3, 32'd0);
        rst = 1'b0;
        @(negedge clk);

        xfer(1, 1'b1, 32'h0000_0004, 32'hDEADBEEF, 1'b0, 1'b0);
        xfer(1, 1'b1, 32'h0000_0014, 32'h12345678, 1'b0, 1'b0);
        xfer(1, 1'b0, 32'h0000_0014, 32'h0, 1'b0, 1'b0);
        xfer(3, 1'b1, 32'h0000_0040, 32'hCAFEF00D, 1'b0, 1'b0);
        xfer(3, 1'b0, 32'h0000_0040, 32'h0, 1'b0, 1'b0);

        xfer(1, 1'b1, 32'h0000_0100, 32'hA1B2C3D4, 1'b1, 1'b0);
        xfer(1, 1'b0, 32'h0000_0100, 32'h0, 1'b0, 1'b1);

        adr = 32'h0000_0014; we = 1'b0; cyc1 = 1'b1; stb1 = 1'b1;
        @(posedge clk);
        @(negedge clk);
        cyc1 = 1'b0; stb1 = 1'b0;
        seen = 1'b0;
        repeat (6) begin
            @(negedge clk);
            if (ack1) seen = 1'b1;
        end
        chk("abort_no_ack", {31'd0, seen}, 32'd0);
        xfer(1, 1'b1, 32'h0000_0018, 32'h0BADF00D, 1'b0, 1'b0);
        xfer(1, 1'b0, 32'h0000_0018, 32'h0, 1'b0, 1'b0);

        adr = 32'h0000_0020; wdat = 32'h5555AAAA; we = 1'b1; cyc1 = 1'b1; stb1 = 1'b1;
        @(posedge clk);
        @(negedge clk);
        chk("pre_rst_csr_we", {31'd0, csr_we1}, 32'd1);
        rst = 1'b1;
        #1;
        chk("async_rst_csr_we", {31'd0, csr_we1}, 32'd0);
        chk("async_rst_ack", {31'd0, ack1}, 32'd0);
        cyc1 = 1'b0; stb1 = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        xfer(1, 1'b0, 32'h0000_0020, 32'h0, 1'b0, 1'b0);
        xfer(1, 1'b1, 32'h8001_0010, 32'h13579BDF, 1'b0, 1'b0);
        xfer(1, 1'b0, 32'h0000_0010, 32'h0, 1'b0, 1'b0);

        for (int k = 0; k < 2; k++) begin
            int which;
            bit ph;
            which = (k == 0) ? 1 : 3;
            ph = 1'b0;
            for (int i = 0; i < 25; i++) begin
                logic [31:0] a;
                logic        w;
                bit          h;
                a = ($urandom & 32'hFFFF_0000) | ($urandom_range(0, 15) << 12)
                  | ($urandom_range(0, 7) << 2) | $urandom_range(0, 3);
                w = 1'($urandom_range(0, 1));
                h = (i < 24) ? 1'($urandom_range(0, 1)) : 1'b0;
                xfer(which, w, a, $urandom, h, ph);
                ph = h;
            end
        end

        repeat (4) @(negedge clk);
        chk("q1_drained", q1.size(), 32'd0);
        chk("q3_drained", q3.size(), 32'd0);
        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
